// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit hex 7-seg driver with tear-free double buffer; LEADING_ZERO_BLANK_EN blanks leading zeros
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);
   localparam int cw = $clog2(REFRESH_DIV);
   localparam int iw = $clog2(NUM_DIGITS);
   localparam logic [15:0][6:0] hex_lut = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
   logic [cw-1:0]                  cnt;
   logic [iw-1:0]                  idx;
   logic [NUM_DIGITS-1:0][3:0]     shadow_val, pend_val;
   logic [NUM_DIGITS-1:0]          shadow_dp, pend_dp, supp;
   logic                           pend_flag, slot_end, wrap, dark;
   assign slot_end = cnt == cw'(REFRESH_DIV - 1);
   assign wrap     = slot_end && idx == iw'(NUM_DIGITS - 1);
   assign dark     = int'(cnt) < BLANK_CYCLES || !digit_en[idx] || supp[idx];
`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_next;
   logic                  all_zero;
   always_comb begin
      lz_next  = '0;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         all_zero   = all_zero && pend_val[i] == 4'h0;
         lz_next[i] = all_zero;
      end
   end
   // mask tracks the shadow, so it is captured on the same edge as the transfer
   always_ff @(posedge clk)
      if (reset) supp <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      else if (wrap && pend_flag) supp <= lz_next;
`else
   assign supp = '0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         frame_done <= 1'b0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_flag  <= 1'b0;
         an         <= '1;
         seg        <= 7'h7F;
         dp         <= 1'b1;
      end else begin
         cnt        <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end) idx <= wrap ? '0 : idx + 1'b1;
         frame_done <= wrap;
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         // a load on the wrap edge keeps the flag set for the following frame
         pend_flag  <= load || (pend_flag && !wrap);
         if (wrap && pend_flag) begin
            shadow_val <= pend_val;
            shadow_dp  <= pend_dp;
         end
         an         <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
         seg        <= dark ? 7'h7F : hex_lut[shadow_val[idx]];
         dp         <= dark || !shadow_dp[idx];
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scoreboard bench, 4 digits, 4-cycle slots, 1 blank cycle
module tb_seg7_scan_driver;
   logic        clk = 1'b0, reset = 1'b1, load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0, digit_en = 4'hF, an;
   logic [6:0]  seg;
   logic        dp, frame_done;
   int          checks = 0, errors = 0, cyc = 0;
   logic [11:0] q[$];

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
      .digit_en(digit_en), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [15:0] v, input logic [3:0] p);
      value = v;
      dp_in = p;
      load  = 1'b1;
   endtask

   task automatic slot(input logic [3:0] a, input logic [6:0] s, input logic d);
      repeat (3) q.push_back({a, s, d});
   endtask

   task automatic digits(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
      slot(4'b1110, s0, 1'b1);
      slot(4'b1101, s1, 1'b1);
      slot(4'b1011, s2, 1'b1);
      slot(4'b0111, s3, 1'b1);
   endtask

   always @(negedge clk) begin
      logic [11:0] e;
      checks++;
      if (frame_done !== (cyc != 0 && cyc % 16 == 0)) begin
         errors++;
         $display("FAIL frame_done cyc=%0d: got %b expected %b", cyc, frame_done, cyc != 0 && cyc % 16 == 0);
      end
      checks++;
      if ($countones(~an) > 1) begin
         errors++;
         $display("FAIL onehot cyc=%0d: got an=%b expected at most one low", cyc, an);
      end
      checks++;
      if (an === 4'hF) begin
         if (seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL dark cyc=%0d: got seg=%b dp=%b expected seg=1111111 dp=1", cyc, seg, dp);
         end
      end else if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_lit cyc=%0d: got an=%b seg=%b dp=%b expected dark", cyc, an, seg, dp);
      end else begin
         e = q.pop_front();
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL lit cyc=%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                     cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset: got %b expected %b", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      reset = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      slot(4'b1110, 7'b1000000, 1'b1);
`else
      digits(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif
      while (cyc < 128) begin
         tick;
         load = 1'b0;
         case (cyc)
            1: begin
               checks++;
               if (an !== 4'hF) begin
                  errors++;
                  $display("FAIL first_blank: got an=%b expected 1111", an);
               end
            end
            4:  ld(16'h1234, 4'h0);
            16: digits(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
            32: digits(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
            41: ld(16'hABCD, 4'h0);
            48: digits(7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000);
            51: ld(16'h1111, 4'h0);
            57: ld(16'h2222, 4'h0);
            63: ld(16'h3333, 4'h0);
            64: digits(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);
            80: digits(7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000);
            87: ld(16'h5678, 4'b0010);
            96: begin
               digit_en = 4'b1010;
               slot(4'b1101, 7'b1111000, 1'b0);
               slot(4'b0111, 7'b0010010, 1'b1);
            end
            99: ld(16'h0050, 4'h0);
            112: begin
               digit_en = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
               slot(4'b1110, 7'b1000000, 1'b1);
               slot(4'b1101, 7'b0010010, 1'b1);
`else
               digits(7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000);
`endif
            end
            default: ;
         endcase
      end
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
